// File: rtl/bcd_decoder_module.sv
// KPN node: reads 4-digit packed BCD tokens, converts them to binary with an iterative
// reverse double-dabble and writes the result downstream. Optional macro: BCD_DECODE_CHECK_EN.
module bcd_decoder_module (
  input  logic        clk,
  input  logic        reset,
  input  logic        empty,
  output logic        rd,
  input  logic [15:0] entry_1,
  input  logic        full,
  output logic        wr,
  output logic [15:0] output_1,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_CONV,
    S_WRITE
  } state_t;

  state_t      r_state;
  logic [15:0] r_bcd;
  logic [13:0] r_bin;
  logic [3:0]  r_cnt;
  logic        r_rd;
  logic        r_wr;
  logic [15:0] r_out;
  logic        r_busy;

  logic [15:0] w_bcd_raw;
  logic [15:0] w_bcd_nxt;
  logic [13:0] w_bin_nxt;
  logic [13:0] w_fin_bin;
  logic [15:0] w_out_val;

  // Handshake: rd is a one-cycle strobe; upstream data is valid in the following
  // (LATCH) cycle. wr is a one-cycle strobe issued only in a cycle where full was low
  // at the deciding edge; output_1 is valid while wr is high and holds afterwards.

  // One reverse double-dabble step: the BCD LSB drops into the binary MSB, then any
  // nibble that received a carry (>= 8) is corrected from weight 8 to weight 5.
  assign w_bcd_raw = {1'b0, r_bcd[15:1]};
  assign w_bin_nxt = {r_bcd[0], r_bin[13:1]};

  always_comb begin
    w_bcd_nxt = w_bcd_raw;
    for (int i = 0; i < 4; i++) begin
      if (w_bcd_raw[4*i+3]) begin
        w_bcd_nxt[4*i +: 4] = w_bcd_raw[4*i +: 4] - 4'd3;
      end
    end
  end

  // The final iteration's result is forwarded so the write can happen on entry to WRITE.
  assign w_fin_bin = (r_state == S_CONV) ? w_bin_nxt : r_bin;

`ifdef BCD_DECODE_CHECK_EN
  logic r_invalid;
  logic r_err;
  logic w_bad_digit;

  assign w_bad_digit = (entry_1[15:12] > 4'd9) || (entry_1[11:8] > 4'd9) ||
                       (entry_1[7:4]   > 4'd9) || (entry_1[3:0]  > 4'd9);
  assign w_out_val   = r_invalid ? 16'hFFFF : {2'b00, w_fin_bin};
  assign err         = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_invalid <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == S_LATCH) begin
        r_invalid <= w_bad_digit;
      end
      if (((r_state == S_CONV) && (r_cnt == 4'd0) && !full) ||
          ((r_state == S_WRITE) && !r_wr && !full)) begin
        r_err <= r_invalid;
      end
    end
  end
`else
  assign w_out_val = {2'b00, w_fin_bin};
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_bcd   <= 16'h0000;
      r_bin   <= 14'h0000;
      r_cnt   <= 4'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_out   <= 16'h0000;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!empty) begin
            r_state <= S_READ;
            r_rd    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_READ: begin
          r_state <= S_LATCH;
          r_rd    <= 1'b0;
        end
        S_LATCH: begin
          r_bcd   <= entry_1;
          r_bin   <= 14'h0000;
          r_cnt   <= 4'd13;
          r_state <= S_CONV;
        end
        S_CONV: begin
          r_bcd <= w_bcd_nxt;
          r_bin <= w_bin_nxt;
          if (r_cnt == 4'd0) begin
            r_state <= S_WRITE;
            if (!full) begin
              r_wr  <= 1'b1;
              r_out <= w_out_val;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_WRITE: begin
          if (r_wr) begin
            r_wr    <= 1'b0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (!full) begin
            r_wr  <= 1'b1;
            r_out <= w_out_val;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_rd    <= 1'b0;
          r_wr    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rd       = r_rd;
  assign wr       = r_wr;
  assign output_1 = r_out;
  assign busy     = r_busy;

endmodule

// File: tb/tb_bcd_decoder_module.sv
// Directed bench for bcd_decoder_module: conversion values, latency, backpressure,
// idle behaviour, invalid digits and mid-conversion reset.
module tb_bcd_decoder_module;

  logic        clk = 1'b0;
  logic        reset;
  logic        empty;
  logic        rd;
  logic [15:0] entry_1;
  logic        full;
  logic        wr;
  logic [15:0] output_1;
  logic        err;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int last_wr_cyc = 0;
  logic [15:0] exp_q[$];

  bcd_decoder_module dut (
    .clk      (clk),
    .reset    (reset),
    .empty    (empty),
    .rd       (rd),
    .entry_1  (entry_1),
    .full     (full),
    .wr       (wr),
    .output_1 (output_1),
    .err      (err),
    .busy     (busy)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Strobe monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (rd) rd_cnt <= rd_cnt + 1;
      if (wr) wr_cnt <= wr_cnt + 1;
      if (rd && wr) check("rd_wr_overlap", {31'd0, rd & wr}, 32'd0);
    end
  end

  // Driver: presents one token, optionally holds full for full_cycles samples
  // starting at c15, and checks latency, data and err of the resulting write.
  task automatic send_token(input logic [15:0] tok, input logic [15:0] exp_val,
                            input logic exp_err, input int full_cycles);
    bit seen;
    int k;
    logic [15:0] e;
    entry_1 = tok;
    empty   = 1'b0;
    exp_q.push_back(exp_val);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rd) seen = 1;
    end
    empty = 1'b1;
    if (!seen) begin
      check("rd_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
      return;
    end
    seen = 0;
    k = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (i == 2) entry_1 = 16'($urandom_range(0, 65535));
      if (full_cycles > 0 && i == 15) full = 1'b1;
      if (full_cycles > 0 && i == 15 + full_cycles) full = 1'b0;
      if (wr) begin
        seen = 1;
        k = i;
      end
    end
    full = 1'b0;
    e = exp_q.pop_front();
    if (!seen) begin
      check("wr_timeout", 32'd0, 32'd1);
      return;
    end
    check("latency", k, 16 + full_cycles);
    check("data", {16'd0, output_1}, {16'd0, e});
    check("err", {31'd0, err}, {31'd0, exp_err});
    last_wr_cyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w1;
    int rd0;
    int wr0;
    logic [15:0] held;
    logic [15:0] bad_exp;
    logic        bad_err;
    bit          quiet;

    reset   = 1'b1;
    empty   = 1'b1;
    full    = 1'b0;
    entry_1 = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_rd", {31'd0, rd}, 32'd0);
    check("rst_wr", {31'd0, wr}, 32'd0);
    check("rst_out", {16'd0, output_1}, 32'h0000);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic conversion
    send_token(16'h1234, 16'h04D2, 1'b0, 0);

    // Bounds back to back
    send_token(16'h0000, 16'h0000, 1'b0, 0);
    w1 = last_wr_cyc;
    send_token(16'h9999, 16'h270F, 1'b0, 0);
    check("b2b_gap", last_wr_cyc - w1, 32'd18);

    // Backpressure
    repeat (2) @(negedge clk);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    send_token(16'h0042, 16'h002A, 1'b0, 5);
    repeat (3) @(negedge clk);
    check("bp_rd_count", rd_cnt - rd0, 32'd1);
    check("bp_wr_count", wr_cnt - wr0, 32'd1);

    // Empty source
    held  = output_1;
    quiet = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd || wr || busy || output_1 !== held) quiet = 0;
    end
    check("idle_quiet", {31'd0, quiet}, 32'd1);
    check("idle_hold", {16'd0, output_1}, 32'h002A);

    // Invalid digit
`ifdef BCD_DECODE_CHECK_EN
    bad_exp = 16'hFFFF;
    bad_err = 1'b1;
`else
    bad_exp = 16'h0518;
    bad_err = 1'b0;
`endif
    send_token(16'h12A4, bad_exp, bad_err, 0);
    send_token(16'h0007, 16'h0007, 1'b0, 0);

    // Reset mid-conversion
    entry_1 = 16'h5555;
    empty   = 1'b0;
    quiet   = 0;
    for (int i = 0; i < 20 && !quiet; i++) begin
      @(negedge clk);
      if (rd) quiet = 1;
    end
    empty = 1'b1;
    check("mid_rd_seen", {31'd0, quiet}, 32'd1);
    repeat (8) @(negedge clk);
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_rd", {31'd0, rd}, 32'd0);
    check("mid_rst_wr", {31'd0, wr}, 32'd0);
    check("mid_rst_out", {16'd0, output_1}, 32'h0000);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wr0 = wr_cnt;
    repeat (30) @(negedge clk);
    check("mid_no_wr", wr_cnt - wr0, 32'd0);
    send_token(16'h0100, 16'h0064, 1'b0, 0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
